sym_vn_lut_pingpong: RTL
========================

# sym_vn_lut_pingpong

Parametrised successor of the four-port symmetric variable-node IB-LUT read pipeline. It serves PORT_NUM independent 2-input lookup channels through a fixed 2-stage pipeline with per-channel valid tags. It holds the LUT in two ping-pong pages, and an internal loader FSM streams a new table into the shadow page while reads continue from the active page. It sits between the VNU message buses and the IB-LUT update controller, so decoding does not stall during table reloads.

## Interface
- QUAN_SIZE, 3, message width Q in bits; also the LUT entry width.
- PORT_NUM, 4, number of independent read channels.
- ENTRY_ADDR, 2*QUAN_SIZE-1, per-page entry address width; DEPTH = 2^ENTRY_ADDR entries per page.

- sys_clk  in  1  single clock for read and write.
- rstn  in  1  reset, synchronous, active-low.
- rd_valid_in  in  PORT_NUM  per-channel read request valid.
- transpose_en_in  in  PORT_NUM  per-channel incoming transpose flag.
- y0_in  in  PORT_NUM*Q  first message per channel; channel k occupies [k*Q+Q-1:k*Q].
- y1_in  in  PORT_NUM*Q  second message per channel; same packing as y0_in.
- t_c_out  out  PORT_NUM*Q  LUT output per channel.
- transpose_en_out  out  PORT_NUM  per-channel symmetry flag aligned with t_c_out.
- rd_valid_out  out  PORT_NUM  per-channel output valid.
- load_start  in  1  pulse that begins loading the shadow page.
- load_abort  in  1  abandons a load in progress; no page swap.
- lut_wr_valid  in  1  load data valid.
- lut_wr_data  in  Q  load data; entries arrive in address order 0..DEPTH-1.
- load_busy  out  1  high in states LOAD and COMMIT.
- load_done  out  1  one-cycle pulse in the cycle after the page swap.
- active_page  out  1  index of the page currently serving reads.

## Operation
**Symmetry fold (combinational, per channel k)**
- msb = transpose_en_in[k] ^ y0[Q-1].
- y0f[i] = y0[i] ^ y0[Q-1] for i < Q-1.
- y1f = msb ? ~y1 : y1.
- Read address = {y0f[Q-2:0], y1f}.

**Stage 0 register** captures, per channel:
- address, msb, rd_valid_in[k];
- active_page at the sampling edge (the page tag).

**Stage 1** reads mem[page tag][address] into the output register. msb and valid advance alongside it.

**Outputs**
- t_c_out is the registered LUT word.
- transpose_en_out is the delayed msb.
- rd_valid_out is the delayed valid.
- The registers update every cycle regardless of valid. Data is meaningful only when valid is high.

**Loader FSM**
- IDLE: load_start → LOAD, with wr_cnt cleared to 0.
- LOAD: on each lut_wr_valid, write mem[~active_page][wr_cnt] = lut_wr_data and increment wr_cnt.
  - A write at wr_cnt == DEPTH-1 → COMMIT.
  - load_abort → IDLE; wr_cnt cleared; no swap.
  - load_abort in the same cycle as the final write wins: the write is performed, but there is no swap.
- COMMIT: active_page toggles at the end of this cycle → IDLE. load_done is asserted in the following cycle.
- load_start outside IDLE is ignored. lut_wr_valid outside LOAD is ignored.

**Boundary rules**
- Loads write only the shadow page, so read/write collisions are impossible.
- A partially loaded shadow page is never exposed.
- A read sampled in the COMMIT cycle uses the old page. Reads sampled from the next cycle use the new page.
- Reset during LOAD or COMMIT returns the FSM to IDLE with no swap; shadow contents are undefined.
- LUT memory is not reset; contents after power-up are undefined until loaded.

## Timing
- Read latency is 2 cycles: a request at edge n appears at edge n+2.
- Throughput is one request per channel per cycle, with no back-pressure.
- Load takes DEPTH valid beats, then one COMMIT cycle.
- Minimum time from load_start to load_done is DEPTH+2 cycles.
- Reset values (rstn low at a sys_clk edge):
  - rd_valid_out = 0, t_c_out = 0, transpose_en_out = 0;
  - load_busy = 0, load_done = 0, active_page = 0;
  - FSM in IDLE, wr_cnt = 0;
  - all pipeline registers cleared.

## Test plan
- **Fold/address:** load page with mem[a] = a[2:0] (loaded into page 1). Then, on channel 2, apply y0 = 3'b110, y1 = 3'b010, en = 0, valid = 1.
  - Expect address 13 and t_c = 3'b101.
  - Expect transpose_en_out = 1 and rd_valid_out[2] = 1 exactly 2 cycles later.
- **All-channel throughput:** drive PORT_NUM distinct requests every cycle for 40 cycles. Expect each channel's output to equal a software model, delayed by 2, with no bubbles.
- **Ping-pong under traffic:** with page 0 holding all 3'b000, load 32 entries of 3'b111 while reads run continuously.
  - Reads sampled up to and including COMMIT return 0; later reads return 7.
  - load_done pulses once; active_page goes 0→1.
- **Abort:** send load_start and 20 beats, then load_abort. Expect load_busy to fall, no load_done, active_page unchanged, and reads unchanged.
- **Gapped load and ignored controls:** insert random lut_wr_valid gaps, plus a second load_start mid-LOAD. Expect the count to be unaffected and the swap only after the 32nd beat.
- **Reset mid-load:** assert rstn = 0 at beat 10. Expect all outputs 0, active_page = 0, and IDLE; a fresh load then completes normally.

Source files
------------

// File: rtl/sym_vn_lut_pingpong_if.sv
// Bus bundle for the ping-pong IB-LUT: the per-channel read path and the table loader stream.
// The master side drives requests and load data; the slave side (the LUT block) returns results and status.
interface sym_vn_lut_pingpong_if #(
  parameter int QUAN_SIZE = 3,
  parameter int PORT_NUM  = 4
);
  logic [PORT_NUM-1:0]           rd_valid_in;
  logic [PORT_NUM-1:0]           transpose_en_in;
  logic [PORT_NUM*QUAN_SIZE-1:0] y0_in;
  logic [PORT_NUM*QUAN_SIZE-1:0] y1_in;
  logic [PORT_NUM*QUAN_SIZE-1:0] t_c_out;
  logic [PORT_NUM-1:0]           transpose_en_out;
  logic [PORT_NUM-1:0]           rd_valid_out;
  logic                          load_start;
  logic                          load_abort;
  logic                          lut_wr_valid;
  logic [QUAN_SIZE-1:0]          lut_wr_data;
  logic                          load_busy;
  logic                          load_done;
  logic                          active_page;

  modport master (
    output rd_valid_in, transpose_en_in, y0_in, y1_in,
    output load_start, load_abort, lut_wr_valid, lut_wr_data,
    input  t_c_out, transpose_en_out, rd_valid_out,
    input  load_busy, load_done, active_page
  );

  modport slave (
    input  rd_valid_in, transpose_en_in, y0_in, y1_in,
    input  load_start, load_abort, lut_wr_valid, lut_wr_data,
    output t_c_out, transpose_en_out, rd_valid_out,
    output load_busy, load_done, active_page
  );
endinterface

// File: rtl/sym_vn_lut_pingpong.sv
// Multi-channel symmetric variable-node IB-LUT with a 2-stage read pipeline and two table pages;
// a loader fills the shadow page while reads are served from the active page, then swaps them.
module sym_vn_lut_pingpong #(
  parameter int QUAN_SIZE  = 3,
  parameter int PORT_NUM   = 4,
  parameter int ENTRY_ADDR = 2*QUAN_SIZE-1
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  sym_vn_lut_pingpong_if.slave bus
);
  localparam int Q     = QUAN_SIZE;
  localparam int DEPTH = 1 << ENTRY_ADDR;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t                  state_q, state_d;
  logic [ENTRY_ADDR-1:0]   wr_cnt_q, wr_cnt_d;
  logic                    active_page_q, active_page_d;
  logic                    load_done_q, load_done_d;
  logic                    wr_en;

  logic [Q-1:0]            lut_q [2][DEPTH];

  logic [ENTRY_ADDR:0]     fold_w [PORT_NUM];
  logic [ENTRY_ADDR-1:0]   addr_q [PORT_NUM];
  logic [ENTRY_ADDR-1:0]   addr_d [PORT_NUM];
  logic [PORT_NUM-1:0]     msb0_q, msb0_d, vld0_q, vld0_d;
  logic                    page_q, page_d;
  logic [PORT_NUM*Q-1:0]   tc_q, tc_d;
  logic [PORT_NUM-1:0]     msb1_q, msb1_d, vld1_q, vld1_d;

  // Fold the message pair onto the half-table; returns {msb, address}.
  function automatic logic [ENTRY_ADDR:0] fold(input logic en, input logic [Q-1:0] y0,
                                               input logic [Q-1:0] y1);
    logic         msb;
    logic [Q-2:0] y0f;
    logic [Q-1:0] y1f;
    msb = en ^ y0[Q-1];
    y0f = y0[Q-2:0] ^ {(Q-1){y0[Q-1]}};
    y1f = msb ? ~y1 : y1;
    return {msb, y0f, y1f};
  endfunction

  always_comb begin
    for (int k = 0; k < PORT_NUM; k++) begin
      fold_w[k] = fold(bus.transpose_en_in[k], bus.y0_in[k*Q +: Q], bus.y1_in[k*Q +: Q]);
    end
  end

  always_comb begin
    msb0_d = '0;
    tc_d   = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      addr_d[k]        = fold_w[k][ENTRY_ADDR-1:0];
      msb0_d[k]        = fold_w[k][ENTRY_ADDR];
      tc_d[k*Q +: Q]   = lut_q[page_q][addr_q[k]];
    end
    vld0_d = bus.rd_valid_in;
    page_d = active_page_q;
    msb1_d = msb0_q;
    vld1_d = vld0_q;
  end

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    active_page_d = active_page_q;
    load_done_d   = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d  = LOAD;
          wr_cnt_d = '0;
        end
      end
      LOAD: begin
        if (bus.lut_wr_valid) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + ENTRY_ADDR'(1);
        end
        // An abort overrides the final beat: that write still lands, but the page never swaps.
        if (bus.load_abort) begin
          state_d  = IDLE;
          wr_cnt_d = '0;
        end else if (bus.lut_wr_valid && (wr_cnt_q == ENTRY_ADDR'(DEPTH-1))) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        active_page_d = ~active_page_q;
        load_done_d   = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      wr_cnt_q      <= '0;
      active_page_q <= 1'b0;
      load_done_q   <= 1'b0;
      msb0_q        <= '0;
      vld0_q        <= '0;
      page_q        <= 1'b0;
      tc_q          <= '0;
      msb1_q        <= '0;
      vld1_q        <= '0;
      for (int k = 0; k < PORT_NUM; k++) addr_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      active_page_q <= active_page_d;
      load_done_q   <= load_done_d;
      msb0_q        <= msb0_d;
      vld0_q        <= vld0_d;
      page_q        <= page_d;
      tc_q          <= tc_d;
      msb1_q        <= msb1_d;
      vld1_q        <= vld1_d;
      for (int k = 0; k < PORT_NUM; k++) addr_q[k] <= addr_d[k];
    end
  end

  // The table itself is never reset; only the shadow page is ever written.
  always_ff @(posedge sys_clk) begin
    if (rstn && wr_en) lut_q[~active_page_q][wr_cnt_q] <= bus.lut_wr_data;
  end

  assign bus.t_c_out          = tc_q;
  assign bus.transpose_en_out = msb1_q;
  assign bus.rd_valid_out     = vld1_q;
  assign bus.load_busy        = (state_q != IDLE);
  assign bus.load_done        = load_done_q;
  assign bus.active_page      = active_page_q;
endmodule
